// File: rtl/channel_config_regs_if.sv
// Register bus between the command decoder and channel_config_regs.
// The decoder side is the master; the register bank is the slave.
interface channel_config_regs_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] i_addr;
   logic [DATA_WIDTH-1:0] i_data;
   logic                  i_wr;
   logic                  i_rd;
   logic [DATA_WIDTH-1:0] o_data;
   logic                  o_rd_valid;

   modport master (
      output i_addr, i_data, i_wr, i_rd,
      input  o_data, o_rd_valid
   );

   modport slave (
      input  i_addr, i_data, i_wr, i_rd,
      output o_data, o_rd_valid
   );
endinterface

// File: rtl/channel_config_regs.sv
// Double-buffered channel enable/selector bank. Software writes the shadow copy;
// the active copy follows atomically, either at once (NOW) or on the next i_sync after ARM.
module channel_config_regs #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_CH     = 8,
   parameter int SEL_WIDTH  = 3,
   parameter int BASE_ADDR  = 0
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   channel_config_regs_if.slave           bus,
   input  logic                           i_sync,
   output logic [NUM_CH-1:0]              o_ch_ena,
   output logic [NUM_CH*SEL_WIDTH-1:0]    o_ch_sel,
   output logic                           o_pending,
   output logic                           o_commit
);

   logic [NUM_CH-1:0]           ena_sh;
   logic [NUM_CH-1:0]           ena_act;
   logic [NUM_CH*SEL_WIDTH-1:0] sel_sh;
   logic [NUM_CH*SEL_WIDTH-1:0] sel_act;
   logic                        pending;
   logic                        lock;
   logic                        err;
   logic [15:0]                 commit_cnt;

   logic [ADDR_WIDTH-1:0] off;
   logic                  hit_ena_sh, hit_ena_set, hit_ena_clr, hit_ctrl;
   logic                  hit_status, hit_ena_act, hit_sel_sh, hit_sel_act;
   logic [NUM_CH-1:0]     sel_sh_vec, sel_act_vec;
   logic                  unmapped, shadow_target;
   logic                  wr_accept, wr_err, rd_any, rd_err;
   logic                  ctrl_ok, commit_now, err_clr;
   logic [DATA_WIDTH-1:0] rd_word;

   assign off         = bus.i_addr - ADDR_WIDTH'(BASE_ADDR);
   assign hit_ena_sh  = (off == ADDR_WIDTH'(8'h00));
   assign hit_ena_set = (off == ADDR_WIDTH'(8'h01));
   assign hit_ena_clr = (off == ADDR_WIDTH'(8'h02));
   assign hit_ctrl    = (off == ADDR_WIDTH'(8'h03));
   assign hit_status  = (off == ADDR_WIDTH'(8'h04));
   assign hit_ena_act = (off == ADDR_WIDTH'(8'h05));

   always_comb begin
      sel_sh_vec  = '0;
      sel_act_vec = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         sel_sh_vec[k]  = (off == ADDR_WIDTH'(8'h10 + k));
         sel_act_vec[k] = (off == ADDR_WIDTH'(8'h20 + k));
      end
   end

   assign hit_sel_sh    = |sel_sh_vec;
   assign hit_sel_act   = |sel_act_vec;
   assign unmapped      = ~(hit_ena_sh | hit_ena_set | hit_ena_clr | hit_ctrl | hit_status |
                            hit_ena_act | hit_sel_sh | hit_sel_act);
   assign shadow_target = hit_ena_sh | hit_ena_set | hit_ena_clr | hit_ctrl | hit_sel_sh;

   // A write wins over a simultaneous read; lock freezes shadows and CTRL but not the err W1C.
   assign wr_accept  = bus.i_wr & shadow_target & ~lock;
   assign wr_err     = bus.i_wr & ((shadow_target & lock) | hit_ena_act | hit_sel_act | unmapped);
   assign rd_any     = bus.i_rd & ~bus.i_wr;
   assign rd_err     = rd_any & unmapped;
   assign err_clr    = bus.i_wr & hit_status & bus.i_data[2];
   assign ctrl_ok    = wr_accept & hit_ctrl;
   assign commit_now = (ctrl_ok & bus.i_data[1]) | (i_sync & pending);

   always_comb begin
      rd_word = '0;
      if (hit_ena_sh)  rd_word[NUM_CH-1:0] = ena_sh;
      if (hit_ena_act) rd_word[NUM_CH-1:0] = ena_act;
      if (hit_status)  rd_word = DATA_WIDTH'({commit_cnt, 13'd0, err, lock, pending});
      for (int k = 0; k < NUM_CH; k++) begin
         if (sel_sh_vec[k])  rd_word[SEL_WIDTH-1:0] = sel_sh[k*SEL_WIDTH +: SEL_WIDTH];
         if (sel_act_vec[k]) rd_word[SEL_WIDTH-1:0] = sel_act[k*SEL_WIDTH +: SEL_WIDTH];
      end
   end

   // Commit copies the shadows as they stood before this edge's write, which nonblocking gives us.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         ena_sh         <= '0;
         ena_act        <= '0;
         sel_sh         <= '0;
         sel_act        <= '0;
         pending        <= 1'b0;
         lock           <= 1'b0;
         err            <= 1'b0;
         commit_cnt     <= '0;
         o_commit       <= 1'b0;
         bus.o_data     <= '0;
         bus.o_rd_valid <= 1'b0;
      end else begin
         if (wr_accept) begin
            if (hit_ena_sh)  ena_sh <= bus.i_data[NUM_CH-1:0];
            if (hit_ena_set) ena_sh <= ena_sh | bus.i_data[NUM_CH-1:0];
            if (hit_ena_clr) ena_sh <= ena_sh & ~bus.i_data[NUM_CH-1:0];
            for (int k = 0; k < NUM_CH; k++) begin
               if (sel_sh_vec[k]) sel_sh[k*SEL_WIDTH +: SEL_WIDTH] <= bus.i_data[SEL_WIDTH-1:0];
            end
            if (hit_ctrl && bus.i_data[2]) lock <= 1'b1;
         end

         if (commit_now) begin
            ena_act    <= ena_sh;
            sel_act    <= sel_sh;
            pending    <= 1'b0;
            commit_cnt <= commit_cnt + 16'd1;
         end else if (ctrl_ok && bus.i_data[0]) begin
            pending <= 1'b1;
         end
         o_commit <= commit_now;

         if (wr_err || rd_err) err <= 1'b1;
         else if (err_clr)     err <= 1'b0;

         bus.o_rd_valid <= rd_any;
         if (rd_any) bus.o_data <= rd_word;
      end
   end

   assign o_ch_ena  = ena_act;
   assign o_ch_sel  = sel_act;
   assign o_pending = pending;

endmodule

// File: tb/tb_channel_config_regs.sv
// Directed bench for channel_config_regs: linear steps, immediate assertions at each check.
module tb_channel_config_regs;

   logic        i_clk;
   logic        i_rst;
   logic        i_sync;
   logic [7:0]  o_ch_ena;
   logic [23:0] o_ch_sel;
   logic        o_pending;
   logic        o_commit;

   int checks   = 0;
   int pass_cnt = 0;
   int fail_cnt = 0;

   channel_config_regs_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

   channel_config_regs #(
      .ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_CH(8), .SEL_WIDTH(3), .BASE_ADDR(0)
   ) dut (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .bus      (bus),
      .i_sync   (i_sync),
      .o_ch_ena (o_ch_ena),
      .o_ch_sel (o_ch_sel),
      .o_pending(o_pending),
      .o_commit (o_commit)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
      @(negedge i_clk);
      bus.i_addr = a;
      bus.i_data = d;
      bus.i_wr   = 1'b1;
      @(negedge i_clk);
      bus.i_wr   = 1'b0;
   endtask

   task automatic read_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
      @(negedge i_clk);
      bus.i_addr = a;
      bus.i_rd   = 1'b1;
      @(negedge i_clk);
      bus.i_rd   = 1'b0;
      check_output({tag, "_vld"}, {31'd0, bus.o_rd_valid}, 32'd1);
      check_output(tag, bus.o_data, exp);
   endtask

   task automatic sync_pulse();
      @(negedge i_clk);
      i_sync = 1'b1;
      @(negedge i_clk);
      i_sync = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge i_clk);
      i_rst = 1'b1;
      @(negedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;
   endtask

   initial begin
      i_rst      = 1'b1;
      i_sync     = 1'b0;
      bus.i_addr = '0;
      bus.i_data = '0;
      bus.i_wr   = 1'b0;
      bus.i_rd   = 1'b0;
      $display("[TB] start");
      @(negedge i_clk);
      @(negedge i_clk);
      check_output("init_ena", {24'd0, o_ch_ena}, 32'h0);
      check_output("init_vld", {31'd0, bus.o_rd_valid}, 32'h0);
      i_rst = 1'b0;

      // Async reset mid-cycle after an immediate commit
      bus_write(8'h00, 32'hFF);
      bus_write(8'h10, 32'h7);
      bus_write(8'h03, 32'h2);
      check_output("pre_rst_ena", {24'd0, o_ch_ena}, 32'hFF);
      check_output("pre_rst_sel", {8'd0, o_ch_sel}, 32'h7);
      check_output("pre_rst_commit", {31'd0, o_commit}, 32'h1);
      #2 i_rst = 1'b1;
      #1;
      check_output("rst_ena", {24'd0, o_ch_ena}, 32'h0);
      check_output("rst_sel", {8'd0, o_ch_sel}, 32'h0);
      check_output("rst_commit", {31'd0, o_commit}, 32'h0);
      check_output("rst_pending", {31'd0, o_pending}, 32'h0);
      @(negedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;
      read_check("rst_status", 8'h04, 32'h0000_0000);
      read_check("rst_ena_sh", 8'h00, 32'h0);

      // Immediate commit
      bus_write(8'h00, 32'hA5);
      bus_write(8'h13, 32'h5);
      bus_write(8'h03, 32'h2);
      check_output("now_ena", {24'd0, o_ch_ena}, 32'hA5);
      check_output("now_sel3", {29'd0, o_ch_sel[11:9]}, 32'h5);
      check_output("now_sel_all", {8'd0, o_ch_sel}, 32'h0000_0A00);
      check_output("now_commit", {31'd0, o_commit}, 32'h1);
      @(negedge i_clk);
      check_output("now_commit_once", {31'd0, o_commit}, 32'h0);
      read_check("now_status", 8'h04, 32'h0001_0000);

      // Armed commit waits for i_sync
      bus_write(8'h00, 32'h0F);
      bus_write(8'h03, 32'h1);
      check_output("arm_pending", {31'd0, o_pending}, 32'h1);
      check_output("arm_ena_hold", {24'd0, o_ch_ena}, 32'hA5);
      check_output("arm_no_commit", {31'd0, o_commit}, 32'h0);
      sync_pulse();
      check_output("sync_ena", {24'd0, o_ch_ena}, 32'h0F);
      check_output("sync_pending", {31'd0, o_pending}, 32'h0);
      check_output("sync_commit", {31'd0, o_commit}, 32'h1);
      sync_pulse();
      check_output("sync2_commit", {31'd0, o_commit}, 32'h0);
      check_output("sync2_ena", {24'd0, o_ch_ena}, 32'h0F);

      // Set/clear, WO readback, commit uses pre-write shadow
      bus_write(8'h00, 32'hF0);
      bus_write(8'h01, 32'h03);
      bus_write(8'h02, 32'h80);
      read_check("setclr_ena_sh", 8'h00, 32'h73);
      read_check("wo_read", 8'h01, 32'h0);
      bus_write(8'h03, 32'h1);
      @(negedge i_clk);
      bus.i_addr = 8'h00;
      bus.i_data = 32'h11;
      bus.i_wr   = 1'b1;
      i_sync     = 1'b1;
      @(negedge i_clk);
      bus.i_wr   = 1'b0;
      i_sync     = 1'b0;
      check_output("same_edge_ena", {24'd0, o_ch_ena}, 32'h73);
      read_check("same_edge_sh", 8'h00, 32'h11);
      read_check("ena_act", 8'h05, 32'h73);
      read_check("sel_act3", 8'h23, 32'h5);

      // ARM and i_sync together while idle: only arms
      @(negedge i_clk);
      bus.i_addr = 8'h03;
      bus.i_data = 32'h1;
      bus.i_wr   = 1'b1;
      i_sync     = 1'b1;
      @(negedge i_clk);
      bus.i_wr   = 1'b0;
      i_sync     = 1'b0;
      check_output("armsync_pending", {31'd0, o_pending}, 32'h1);
      check_output("armsync_commit", {31'd0, o_commit}, 32'h0);
      check_output("armsync_ena", {24'd0, o_ch_ena}, 32'h73);
      sync_pulse();
      check_output("armsync_ena2", {24'd0, o_ch_ena}, 32'h11);

      // Lock with a commit still pending
      bus_write(8'h00, 32'h22);
      bus_write(8'h03, 32'h1);
      bus_write(8'h03, 32'h4);
      bus_write(8'h00, 32'hFF);
      read_check("lock_ena_sh", 8'h00, 32'h22);
      bus_write(8'h03, 32'h2);
      check_output("lock_now_ignored", {31'd0, o_commit}, 32'h0);
      sync_pulse();
      check_output("lock_sync_ena", {24'd0, o_ch_ena}, 32'h22);
      read_check("lock_status", 8'h04, 32'h0005_0006);
      read_check("unmapped_read", 8'h7F, 32'h0);
      bus_write(8'h04, 32'h4);
      read_check("w1c_status", 8'h04, 32'h0005_0002);

      // Simultaneous write and read drops the read
      @(negedge i_clk);
      bus.i_addr = 8'h04;
      bus.i_data = 32'h0;
      bus.i_wr   = 1'b1;
      bus.i_rd   = 1'b1;
      @(negedge i_clk);
      bus.i_wr   = 1'b0;
      bus.i_rd   = 1'b0;
      check_output("wr_rd_no_valid", {31'd0, bus.o_rd_valid}, 32'h0);

      // Commit counter wrap
      apply_reset();
      @(negedge i_clk);
      bus.i_addr = 8'h03;
      bus.i_data = 32'h2;
      bus.i_wr   = 1'b1;
      for (int i = 0; i < 65535; i++) @(negedge i_clk);
      bus.i_wr   = 1'b0;
      read_check("cnt_ffff", 8'h04, 32'hFFFF_0000);
      bus_write(8'h03, 32'h2);
      read_check("cnt_wrap", 8'h04, 32'h0000_0000);

      $display("%0d/%0d checks passed", pass_cnt, checks);
      $finish;
   end

endmodule
